id_stage: RTL and testbench

- Instruction Decode stage, directly downstream of instruction fetch.
- Registers each fetched word with its PC and splits it into fields.
- Tracks pending register and flag writes in a scoreboard, stalls on hazards, and resolves conditional branches.
- Uses valid/ready handshakes to fetch (upstream) and execute (downstream).

---
 rtl/id_stage.sv | 138 +++++++++++++
 tb/tb_id_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: one-entry staging register, field split, per-register
// and flags writeback scoreboard, hazard stall, and in-ID conditional branch resolution.
// Optional performance counters are compiled in with `define ID_PERF_EN.

module id_sb_cnt #(
  parameter int WB_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt <= 2'd0;
    else if (load)       cnt <= 2'(WB_LAT);
    else if (cnt != 2'd0) cnt <= cnt - 2'd1;
  end

  assign busy = (cnt != 2'd0);
endmodule

module id_stage #(
  parameter int WB_LAT = 3,
  parameter int NREGS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_rd,
  output logic [2:0]  out_rs1,
  output logic [2:0]  out_rs2,
  output logic [31:0] out_imm,
  input  logic [3:0]  flags_nzcv,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        flush
`ifdef ID_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] branch_flushes
`endif
);
  localparam logic [6:0] OP_BCOND = 7'b1100001;

  logic             hold;
  logic [31:0]      instr_q, pc_q;
  logic [NREGS-1:0] reg_busy;
  logic             flag_busy;
  logic             is_br, is_wr, hazard, issue, resolve, cond_true;
  logic [31:0]      br_sum;
  logic             unused_carry;

  assign out_opcode = instr_q[31:25];
  assign out_rd     = instr_q[24:22];
  assign out_rs1    = instr_q[21:19];
  assign out_rs2    = instr_q[18:16];
  assign out_imm    = {{16{instr_q[15]}}, instr_q[15:0]};

  assign is_br = (out_opcode == OP_BCOND);
  assign is_wr = ~out_opcode[6];

  // Branches only wait on flags; everything else waits on its source registers.
  assign hazard  = is_br ? flag_busy : (reg_busy[out_rs1] | reg_busy[out_rs2]);
  assign out_valid = hold & ~is_br & ~hazard;
  assign issue     = out_valid & out_ready;
  assign resolve   = hold & is_br & ~hazard;

  always_comb begin
    cond_true = 1'b0;
    case (instr_q[23:22])
      2'b00: cond_true = flags_nzcv[2];
      2'b01: cond_true = ~flags_nzcv[2];
      2'b10: cond_true = flags_nzcv[3] ^ flags_nzcv[0];
      2'b11: cond_true = ~(flags_nzcv[3] ^ flags_nzcv[0]);
      default: cond_true = 1'b0;
    endcase
  end

  assign unused_carry = flags_nzcv[1];

  assign br_taken  = resolve & cond_true;
  assign flush     = br_taken;
  assign br_sum    = pc_q + {out_imm[29:0], 2'b00};
  assign br_target = {br_sum[31:2], 2'b00};

  // A resolving branch frees the slot, so a word may be accepted alongside it.
  assign in_ready = ~reset & (~hold | issue | resolve);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold    <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
    end else if (in_valid && in_ready && !br_taken) begin
      hold    <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
    end else if (issue || resolve) begin
      hold    <= 1'b0;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_sb
    id_sb_cnt #(.WB_LAT(WB_LAT)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .load (issue & is_wr & (out_rd == 3'(g))),
      .busy (reg_busy[g])
    );
  end

  id_sb_cnt #(.WB_LAT(WB_LAT)) u_flag_cnt (
    .clk  (clk),
    .reset(reset),
    .load (issue & is_wr),
    .busy (flag_busy)
  );

`ifdef ID_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= 32'd0;
      branch_flushes <= 16'd0;
    end else begin
      if (hold && hazard && stall_cycles != '1)  stall_cycles   <= stall_cycles + 32'd1;
      if (br_taken && branch_flushes != '1)      branch_flushes <= branch_flushes + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reset/hazard/branch sequences, a decode vector table, and
// randomized traffic against a busy-until-cycle reference model.

module tb_id_stage;
  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [3:0]  flags_nzcv;
  logic        br_taken, flush;
  logic [31:0] br_target;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage #(.WB_LAT(WB_LAT), .NREGS(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .flags_nzcv(flags_nzcv),
    .br_taken(br_taken), .br_target(br_target), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } vec_t;

  vec_t vt[5];

  // Reference model state: a register/flags is busy while cyc <= busy_until.
  bit          m_valid;
  logic [31:0] m_instr, m_pc;
  int          busy_until[8];
  int          fbusy, cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h8000_0000; in_pc = 32'h40;
    out_ready = 1'b1; flags_nzcv = 4'b0000;

    // Reset behaviour
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_br_taken", 32'(br_taken), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_opcode", 32'(out_opcode), 0);
    chk("rst_imm", out_imm, 0);
    @(negedge clk); reset = 1'b0; #1;
    chk("rst_first_ready", 32'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rst_first_valid", 32'(out_valid), 1);
    chk("rst_first_op", 32'(out_opcode), 32'h40);
    idle(5);

    // RAW stall: writer rd=3 then consumer rs1=3
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h02C0_0000; out_ready = 1'b1;
    @(negedge clk); in_instr = 32'h8018_0000; #1;
    chk("raw_wr_issue", 32'(out_valid), 1);
    chk("raw_wr_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      chk("raw_stall_valid", 32'(out_valid), 0);
      chk("raw_stall_ready", 32'(in_ready), 0);
    end
    @(negedge clk); #1;
    chk("raw_release", 32'(out_valid), 1);
    chk("raw_rs1", 32'(out_rs1), 3);
    idle(5);

    // Backpressure
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h0B09_1234; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_instr = 32'h8020_0000; #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_opcode", 32'(out_opcode), 5);
      chk("bp_imm", out_imm, 32'h1234);
      chk("bp_ready", 32'(in_ready), 0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_issue", 32'(out_valid), 1);
    chk("bp_issue_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      chk("bp_dep_stall", 32'(out_valid), 0);
    end
    @(negedge clk); #1;
    chk("bp_dep_release", 32'(out_valid), 1);
    chk("bp_dep_rs1", 32'(out_rs1), 4);
    idle(5);

    // Taken BEQ, concurrent word dropped
    flags_nzcv = 4'b0100;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'hC200_FFFE; in_pc = 32'h100;
    @(negedge clk); in_instr = 32'h8000_0000; in_pc = 32'h200; #1;
    chk("beq_taken", 32'(br_taken), 1);
    chk("beq_flush", 32'(flush), 1);
    chk("beq_target", br_target, 32'h0000_00F8);
    chk("beq_no_out", 32'(out_valid), 0);
    chk("beq_ready", 32'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("beq_pulse_end", 32'(br_taken), 0);
    chk("beq_flush_end", 32'(flush), 0);
    chk("beq_dropped", 32'(out_valid), 0);
    idle(5);

    // Writer then BNE with Z=1: flags hazard, then silent not-taken
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h02C0_0000; in_pc = 32'h300;
    @(negedge clk); in_instr = 32'hC240_0000; in_pc = 32'h304; #1;
    chk("bne_wr_issue", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      chk("bne_hold_taken", 32'(br_taken), 0);
      chk("bne_hold_valid", 32'(out_valid), 0);
      chk("bne_hold_ready", 32'(in_ready), 0);
    end
    @(negedge clk); #1;
    chk("bne_nt_taken", 32'(br_taken), 0);
    chk("bne_nt_flush", 32'(flush), 0);
    chk("bne_nt_valid", 32'(out_valid), 0);
    chk("bne_nt_ready", 32'(in_ready), 1);
    @(negedge clk); #1;
    chk("bne_retired", 32'(out_valid), 0);
    idle(5);

    // BGE wrap-around target
    flags_nzcv = 4'b0000;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'hC2C0_0002; in_pc = 32'hFFFF_FFFC;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("bge_taken", 32'(br_taken), 1);
    chk("bge_wrap", br_target, 32'h0000_0004);
    @(negedge clk); #1;
    chk("bge_pulse_end", 32'(br_taken), 0);
    idle(5);

    // Decode table
    vt[0] = '{32'hFF57_8001, 7'h7F, 3'd5, 3'd2, 3'd7, 32'hFFFF_8001};
    vt[1] = '{32'h0000_0000, 7'h00, 3'd0, 3'd0, 3'd0, 32'h0000_0000};
    vt[2] = '{32'h1234_5678, 7'h09, 3'd0, 3'd6, 3'd4, 32'h0000_5678};
    vt[3] = '{32'hAAAA_AAAA, 7'h55, 3'd2, 3'd5, 3'd2, 32'hFFFF_AAAA};
    vt[4] = '{32'h7FFF_7FFF, 7'h3F, 3'd7, 3'd7, 3'd7, 32'h0000_7FFF};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h1000; out_ready = 1'b1; #1;
      chk("tbl_ready", 32'(in_ready), 1);
      @(negedge clk); in_valid = 1'b0; #1;
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_opcode", 32'(out_opcode), 32'(vt[i].op));
      chk("tbl_rd", 32'(out_rd), 32'(vt[i].rd));
      chk("tbl_rs1", 32'(out_rs1), 32'(vt[i].rs1));
      chk("tbl_rs2", 32'(out_rs2), 32'(vt[i].rs2));
      chk("tbl_imm", out_imm, vt[i].imm);
      idle(5);
    end

    // Randomized traffic against the reference model
    m_valid = 0; m_instr = '0; m_pc = '0; fbusy = -100; cyc = 0;
    for (int r = 0; r < 8; r++) busy_until[r] = -100;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] rw, se, exp_tgt;
      logic [6:0]  op;
      logic [2:0]  rd, rs1, rs2;
      bit isbr, haz, exp_ov, resolve, taken, exp_ir, n, z, v;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flags_nzcv = 4'($urandom);
      rw = $urandom;
      if ($urandom_range(0, 3) == 0) rw[31:25] = 7'h61;
      in_instr = rw;
      in_pc = $urandom;
      #1;
      op = m_instr[31:25]; rd = m_instr[24:22]; rs1 = m_instr[21:19]; rs2 = m_instr[18:16];
      isbr = (op == 7'h61);
      haz = isbr ? (cyc <= fbusy) : ((cyc <= busy_until[rs1]) || (cyc <= busy_until[rs2]));
      exp_ov  = m_valid && !isbr && !haz;
      resolve = m_valid && isbr && !haz;
      n = flags_nzcv[3]; z = flags_nzcv[2]; v = flags_nzcv[0];
      case (m_instr[23:22])
        2'd0: taken = z;
        2'd1: taken = !z;
        2'd2: taken = (n != v);
        default: taken = (n == v);
      endcase
      taken = taken && resolve;
      exp_ir = !m_valid || (exp_ov && out_ready) || resolve;
      se = {{16{m_instr[15]}}, m_instr[15:0]};
      exp_tgt = (m_pc + se * 4) & 32'hFFFF_FFFC;
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rnd_br_taken", 32'(br_taken), 32'(taken));
      chk("rnd_flush", 32'(flush), 32'(taken));
      if (taken) chk("rnd_target", br_target, exp_tgt);
      if (exp_ov) begin
        chk("rnd_opcode", 32'(out_opcode), 32'(op));
        chk("rnd_rd", 32'(out_rd), 32'(rd));
        chk("rnd_imm", out_imm, se);
      end
      if (exp_ov && out_ready && !op[6]) begin
        busy_until[rd] = cyc + WB_LAT;
        fbusy = cyc + WB_LAT;
      end
      if (in_valid && exp_ir && !taken) begin
        m_valid = 1; m_instr = in_instr; m_pc = in_pc;
      end else if ((exp_ov && out_ready) || resolve) begin
        m_valid = 0;
      end
      cyc++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
